// File: rtl/vga_timing_sequencer_if.sv
// Configuration channel between the config unit and the VGA timing sequencer.
// Handshake: a timing set transfers on a clock edge where Cfg_valid and
// Cfg_ready are both 1. Cfg_ready depends only on the sequencer's internal
// state, never combinationally on Cfg_valid. Cfg_err is a one-cycle pulse that
// follows an offer that was seen while Cfg_ready=1 but held an invalid set.
//   master : config unit (drives valid + fields, observes ready/err)
//   slave  : vga_timing_sequencer
interface vga_timing_sequencer_if #(
  parameter int W = 11
);
  logic         Cfg_valid;
  logic         Cfg_ready;
  logic         Cfg_err;
  logic [W-1:0] Cfg_h_act;
  logic [W-1:0] Cfg_h_fp;
  logic [W-1:0] Cfg_h_sync;
  logic [W-1:0] Cfg_h_bp;
  logic [W-1:0] Cfg_v_act;
  logic [W-1:0] Cfg_v_fp;
  logic [W-1:0] Cfg_v_sync;
  logic [W-1:0] Cfg_v_bp;

  modport master (
    output Cfg_valid, Cfg_h_act, Cfg_h_fp, Cfg_h_sync, Cfg_h_bp,
           Cfg_v_act, Cfg_v_fp, Cfg_v_sync, Cfg_v_bp,
    input  Cfg_ready, Cfg_err
  );

  modport slave (
    input  Cfg_valid, Cfg_h_act, Cfg_h_fp, Cfg_h_sync, Cfg_h_bp,
           Cfg_v_act, Cfg_v_fp, Cfg_v_sync, Cfg_v_bp,
    output Cfg_ready, Cfg_err
  );
endinterface

// File: rtl/vga_timing_sequencer.sv
// VGA timing sequencer: pixel/line counters, registered sync pulses and
// display-region margins for the colour-assign stage. A live timing set drives
// the scan; a shadow set loaded over the cfg channel becomes live only at a
// frame boundary (or while idle), so margins never change mid-frame.
// Ports:
//   Clk, Rst        pixel clock, asynchronous active-high reset
//   Enable          1 = scan, 0 = return to idle
//   cfg             config channel (slave modport)
//   Count_h/v       pixel / line counters
//   H/V_*_margin    sync+bp and sync+bp+act-1 of the live set
//   Hsync, Vsync    sync pulses, active level SYNC_POL
//   Frame_start     pulse on the Count=(0,0) cycle of a running frame
//   Dbg_state       FSM state (0 = IDLE, 1 = RUN)
module vga_timing_sequencer #(
  parameter int REZ_MAX_WIDTH = 11,
  parameter bit SYNC_POL      = 1'b0,
  parameter int DEF_H_ACT     = 640,
  parameter int DEF_H_FP      = 16,
  parameter int DEF_H_SYNC    = 96,
  parameter int DEF_H_BP      = 48,
  parameter int DEF_V_ACT     = 480,
  parameter int DEF_V_FP      = 10,
  parameter int DEF_V_SYNC    = 2,
  parameter int DEF_V_BP      = 33
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Enable,
  vga_timing_sequencer_if.slave    cfg,
  output logic [REZ_MAX_WIDTH-1:0] Count_h,
  output logic [REZ_MAX_WIDTH-1:0] Count_v,
  output logic [REZ_MAX_WIDTH-1:0] H_left_margin,
  output logic [REZ_MAX_WIDTH-1:0] H_right_margin,
  output logic [REZ_MAX_WIDTH-1:0] V_left_margin,
  output logic [REZ_MAX_WIDTH-1:0] V_right_margin,
  output logic                     Hsync,
  output logic                     Vsync,
  output logic                     Frame_start,
  output logic                     Dbg_state
);
  localparam int W = REZ_MAX_WIDTH;

  typedef struct packed {
    logic [W-1:0] h_act, h_fp, h_sync, h_bp;
    logic [W-1:0] v_act, v_fp, v_sync, v_bp;
  } timing_t;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam timing_t DEF_SET = '{
    h_act: W'(DEF_H_ACT), h_fp: W'(DEF_H_FP), h_sync: W'(DEF_H_SYNC), h_bp: W'(DEF_H_BP),
    v_act: W'(DEF_V_ACT), v_fp: W'(DEF_V_FP), v_sync: W'(DEF_V_SYNC), v_bp: W'(DEF_V_BP)};
  localparam logic [W-1:0] DEF_HL = W'(DEF_H_SYNC + DEF_H_BP);
  localparam logic [W-1:0] DEF_HR = W'(DEF_H_SYNC + DEF_H_BP + DEF_H_ACT - 1);
  localparam logic [W-1:0] DEF_VL = W'(DEF_V_SYNC + DEF_V_BP);
  localparam logic [W-1:0] DEF_VR = W'(DEF_V_SYNC + DEF_V_BP + DEF_V_ACT - 1);
  // 2^W, the largest legal total
  localparam logic [W+1:0] TOT_MAX = {2'b01, {W{1'b0}}};

  state_t       r_state, w_state_nxt;
  timing_t      r_live, r_shadow, w_cfg, w_live_nxt;
  logic         r_pending, r_cfg_err, r_hsync, r_vsync, r_frame_start;
  logic [W-1:0] r_cnt_h, r_cnt_v, w_cnt_h_nxt, w_cnt_v_nxt;
  logic [W-1:0] r_hl, r_hr, r_vl, r_vr;
  logic [W-1:0] w_sh_hl, w_sh_hr, w_sh_vl, w_sh_vr;
  logic [W:0]   w_htot, w_vtot;
  logic [W+1:0] w_cfg_htot, w_cfg_vtot;
  logic         w_h_last, w_v_last, w_apply, w_offer, w_cfg_ok, w_accept;
  logic         w_hs_act, w_vs_act;

  assign w_cfg = '{
    h_act: cfg.Cfg_h_act, h_fp: cfg.Cfg_h_fp, h_sync: cfg.Cfg_h_sync, h_bp: cfg.Cfg_h_bp,
    v_act: cfg.Cfg_v_act, v_fp: cfg.Cfg_v_fp, v_sync: cfg.Cfg_v_sync, v_bp: cfg.Cfg_v_bp};

  // Live totals fit in W+1 bits because only validated sets (<= 2^W) go live.
  assign w_htot = {1'b0, r_live.h_act} + {1'b0, r_live.h_fp} + {1'b0, r_live.h_sync} + {1'b0, r_live.h_bp};
  assign w_vtot = {1'b0, r_live.v_act} + {1'b0, r_live.v_fp} + {1'b0, r_live.v_sync} + {1'b0, r_live.v_bp};

  // Offered totals get two extra bits so four near-maximal fields cannot wrap
  // around and slip past the range check.
  assign w_cfg_htot = {2'b0, w_cfg.h_act} + {2'b0, w_cfg.h_fp} + {2'b0, w_cfg.h_sync} + {2'b0, w_cfg.h_bp};
  assign w_cfg_vtot = {2'b0, w_cfg.v_act} + {2'b0, w_cfg.v_fp} + {2'b0, w_cfg.v_sync} + {2'b0, w_cfg.v_bp};

  assign w_cfg_ok = (w_cfg.h_act != '0) && (w_cfg.h_fp != '0) && (w_cfg.h_sync != '0) &&
                    (w_cfg.h_bp != '0) && (w_cfg.v_act != '0) && (w_cfg.v_fp != '0) &&
                    (w_cfg.v_sync != '0) && (w_cfg.v_bp != '0) &&
                    (w_cfg_htot <= TOT_MAX) && (w_cfg_vtot <= TOT_MAX);

  assign w_offer  = cfg.Cfg_valid && !r_pending;
  assign w_accept = w_offer && w_cfg_ok;

  assign w_h_last = ({1'b0, r_cnt_h} == w_htot - 1'b1);
  assign w_v_last = ({1'b0, r_cnt_v} == w_vtot - 1'b1);

  // A pending set goes live on any idle clock, or on the last pixel of a frame.
  assign w_apply    = r_pending && ((r_state == S_IDLE) || (w_h_last && w_v_last));
  assign w_live_nxt = w_apply ? r_shadow : r_live;

  assign w_sh_hl = r_shadow.h_sync + r_shadow.h_bp;
  assign w_sh_hr = w_sh_hl + r_shadow.h_act - 1'b1;
  assign w_sh_vl = r_shadow.v_sync + r_shadow.v_bp;
  assign w_sh_vr = w_sh_vl + r_shadow.v_act - 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_h_nxt = r_cnt_h;
    w_cnt_v_nxt = r_cnt_v;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_h_nxt = '0;
        w_cnt_v_nxt = '0;
        if (Enable) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!Enable) begin
          w_state_nxt = S_IDLE;
          w_cnt_h_nxt = '0;
          w_cnt_v_nxt = '0;
        end else if (w_h_last) begin
          w_cnt_h_nxt = '0;
          w_cnt_v_nxt = w_v_last ? '0 : r_cnt_v + 1'b1;
        end else begin
          w_cnt_h_nxt = r_cnt_h + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Syncs are decoded from the next counter value against the next live set,
  // so the registered pulse lines up with the counter that produced it.
  assign w_hs_act = (w_state_nxt == S_RUN) && (w_cnt_h_nxt < w_live_nxt.h_sync);
  assign w_vs_act = (w_state_nxt == S_RUN) && (w_cnt_v_nxt < w_live_nxt.v_sync);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state       <= S_IDLE;
      r_cnt_h       <= '0;
      r_cnt_v       <= '0;
      r_live        <= DEF_SET;
      r_shadow      <= DEF_SET;
      r_pending     <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_hl          <= DEF_HL;
      r_hr          <= DEF_HR;
      r_vl          <= DEF_VL;
      r_vr          <= DEF_VR;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt_h       <= w_cnt_h_nxt;
      r_cnt_v       <= w_cnt_v_nxt;
      r_live        <= w_live_nxt;
      if (w_accept) r_shadow <= w_cfg;
      // accept needs !pending and apply needs pending, so they never collide
      r_pending     <= w_accept || (r_pending && !w_apply);
      r_cfg_err     <= w_offer && !w_cfg_ok;
      if (w_apply) begin
        r_hl <= w_sh_hl;
        r_hr <= w_sh_hr;
        r_vl <= w_sh_vl;
        r_vr <= w_sh_vr;
      end
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_frame_start <= (w_state_nxt == S_RUN) && (w_cnt_h_nxt == '0) && (w_cnt_v_nxt == '0);
    end
  end

  assign cfg.Cfg_ready  = ~r_pending;
  assign cfg.Cfg_err    = r_cfg_err;
  assign Count_h        = r_cnt_h;
  assign Count_v        = r_cnt_v;
  assign H_left_margin  = r_hl;
  assign H_right_margin = r_hr;
  assign V_left_margin  = r_vl;
  assign V_right_margin = r_vr;
  assign Hsync          = r_hsync;
  assign Vsync          = r_vsync;
  assign Frame_start    = r_frame_start;
  assign Dbg_state      = (r_state == S_RUN);
endmodule

// File: tb/tb_vga_timing_sequencer.sv
module tb_vga_timing_sequencer;
  localparam int W = 11;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst, Enable;
  always #5 Clk = ~Clk;

  vga_timing_sequencer_if #(.W(W)) cfg_if ();

  logic [W-1:0] Count_h, Count_v, H_left_margin, H_right_margin, V_left_margin, V_right_margin;
  logic         Hsync, Vsync, Frame_start, Dbg_state;

  vga_timing_sequencer #(.REZ_MAX_WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .cfg(cfg_if),
    .Count_h(Count_h), .Count_v(Count_v),
    .H_left_margin(H_left_margin), .H_right_margin(H_right_margin),
    .V_left_margin(V_left_margin), .V_right_margin(V_right_margin),
    .Hsync(Hsync), .Vsync(Vsync), .Frame_start(Frame_start), .Dbg_state(Dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int h, input int v);
    check({tag, ".h"}, 32'(Count_h), 32'(h));
    check({tag, ".v"}, 32'(Count_v), 32'(v));
  endtask

  task automatic check_margins(input string tag, input int hl, input int hr, input int vl, input int vr);
    check({tag, ".hl"}, 32'(H_left_margin),  32'(hl));
    check({tag, ".hr"}, 32'(H_right_margin), 32'(hr));
    check({tag, ".vl"}, 32'(V_left_margin),  32'(vl));
    check({tag, ".vr"}, 32'(V_right_margin), 32'(vr));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic offer(input int ha, input int hf, input int hs, input int hb,
                       input int va, input int vf, input int vs, input int vb);
    cfg_if.Cfg_h_act  = W'(ha);
    cfg_if.Cfg_h_fp   = W'(hf);
    cfg_if.Cfg_h_sync = W'(hs);
    cfg_if.Cfg_h_bp   = W'(hb);
    cfg_if.Cfg_v_act  = W'(va);
    cfg_if.Cfg_v_fp   = W'(vf);
    cfg_if.Cfg_v_sync = W'(vs);
    cfg_if.Cfg_v_bp   = W'(vb);
    cfg_if.Cfg_valid  = 1'b1;
  endtask

  // Sets used below (hand-computed):
  //   A: h 8/2/2/2  (Htot 14, margins 4/11),  v 4/1/1/1 (Vtot 7, margins 2/5)
  //   B: h 6/1/3/2  (Htot 12, margins 5/10),  v 3/1/2/1 (Vtot 7, margins 3/5)
  //   C: h 5/1/1/1  (Htot 8,  margins 2/6),   v 2/1/1/1 (Vtot 5, margins 2/3)
  initial begin
    Rst = 1'b1;
    Enable = 1'b0;
    cfg_if.Cfg_valid = 1'b0;
    offer(1, 1, 1, 1, 1, 1, 1, 1);
    cfg_if.Cfg_valid = 1'b0;
    #1;
    // reset state
    check_cnt("rst_cnt", 0, 0);
    check("rst_hsync", 32'(Hsync), 1);
    check("rst_vsync", 32'(Vsync), 1);
    check("rst_fs", 32'(Frame_start), 0);
    check("rst_err", 32'(cfg_if.Cfg_err), 0);
    check("rst_ready", 32'(cfg_if.Cfg_ready), 1);
    check("rst_state", 32'(Dbg_state), 0);
    check_margins("rst_marg", 144, 783, 35, 514);
    tick(2);
    Rst = 1'b0;
    tick();
    check_cnt("idle_cnt", 0, 0);

    // default timing scan
    Enable = 1'b1;
    tick();
    check_cnt("run0", 0, 0);
    check("run0_fs", 32'(Frame_start), 1);
    check("run0_hs", 32'(Hsync), 0);
    check("run0_vs", 32'(Vsync), 0);
    check("run0_state", 32'(Dbg_state), 1);
    tick(95);
    check_cnt("h95", 95, 0);
    check("h95_hs", 32'(Hsync), 0);
    tick();
    check("h96_hs", 32'(Hsync), 1);
    check("h96_fs", 32'(Frame_start), 0);
    tick(703);
    check_cnt("h799", 799, 0);
    tick();
    check_cnt("wrap1", 0, 1);
    check("v1_vs", 32'(Vsync), 0);
    tick(800);
    check_cnt("wrap2", 0, 2);
    check("v2_vs", 32'(Vsync), 1);

    // rejected offers: zero field, then oversize total (2047+1+1+1 > 2048)
    offer(640, 16, 0, 48, 480, 10, 2, 33);
    tick();
    cfg_if.Cfg_valid = 1'b0;
    check("rej0_err", 32'(cfg_if.Cfg_err), 1);
    check("rej0_ready", 32'(cfg_if.Cfg_ready), 1);
    tick();
    check("rej0_err_end", 32'(cfg_if.Cfg_err), 0);
    check_margins("rej0_marg", 144, 783, 35, 514);
    offer(2047, 1, 1, 1, 4, 1, 1, 1);
    tick();
    cfg_if.Cfg_valid = 1'b0;
    check("rej1_err", 32'(cfg_if.Cfg_err), 1);
    check("rej1_ready", 32'(cfg_if.Cfg_ready), 1);
    tick();

    // accept A mid-frame, then a second offer (B) while pending is refused
    offer(8, 2, 2, 2, 4, 1, 1, 1);
    tick();
    cfg_if.Cfg_valid = 1'b0;
    check("accA_ready", 32'(cfg_if.Cfg_ready), 0);
    check("accA_err", 32'(cfg_if.Cfg_err), 0);
    check_margins("accA_marg", 144, 783, 35, 514);
    offer(6, 1, 3, 2, 3, 1, 2, 1);
    tick();
    cfg_if.Cfg_valid = 1'b0;
    check("busy_ready", 32'(cfg_if.Cfg_ready), 0);
    check("busy_err", 32'(cfg_if.Cfg_err), 0);

    // Enable=0 mid-frame with A pending: idle first, A live one clock later
    Enable = 1'b0;
    tick();
    check_cnt("stop", 0, 0);
    check("stop_hs", 32'(Hsync), 1);
    check("stop_vs", 32'(Vsync), 1);
    check("stop_state", 32'(Dbg_state), 0);
    check_margins("stop_marg", 144, 783, 35, 514);
    tick();
    check_margins("idle_applyA", 4, 11, 2, 5);
    check("idle_ready", 32'(cfg_if.Cfg_ready), 1);
    Enable = 1'b1;
    tick();
    check_cnt("runA", 0, 0);
    check("runA_fs", 32'(Frame_start), 1);

    // B accepted at (1,0) of an A frame; applies at (13,6)->(0,0)
    offer(6, 1, 3, 2, 3, 1, 2, 1);
    tick();
    cfg_if.Cfg_valid = 1'b0;
    check("accB_ready", 32'(cfg_if.Cfg_ready), 0);
    tick(96);
    check_cnt("lastA", 13, 6);
    check_margins("lastA_marg", 4, 11, 2, 5);
    offer(5, 1, 1, 1, 2, 1, 1, 1);  // C offered on the apply clock
    tick();
    check_cnt("frameB", 0, 0);
    check("frameB_fs", 32'(Frame_start), 1);
    check("frameB_ready", 32'(cfg_if.Cfg_ready), 1);
    check("frameB_hs", 32'(Hsync), 0);
    check_margins("frameB_marg", 5, 10, 3, 5);
    tick();
    cfg_if.Cfg_valid = 1'b0;
    check("accC_ready", 32'(cfg_if.Cfg_ready), 0);
    check("accC_err", 32'(cfg_if.Cfg_err), 0);
    check_cnt("accC_cnt", 1, 0);
    tick();
    check("B_h2_hs", 32'(Hsync), 0);
    tick();
    check("B_h3_hs", 32'(Hsync), 1);
    tick(8);
    check_cnt("B_h11", 11, 0);
    tick();
    check_cnt("B_wrap", 0, 1);
    check("B_v1_vs", 32'(Vsync), 0);
    tick(12);
    check("B_v2_vs", 32'(Vsync), 1);
    tick(59);
    check_cnt("lastB", 11, 6);
    check_margins("lastB_marg", 5, 10, 3, 5);
    tick();
    check_cnt("frameC", 0, 0);
    check("frameC_fs", 32'(Frame_start), 1);
    check_margins("frameC_marg", 2, 6, 2, 3);
    tick();
    check("frameC_fs_end", 32'(Frame_start), 0);

    // async reset mid-RUN with A pending: pending discarded
    offer(8, 2, 2, 2, 4, 1, 1, 1);
    tick();
    cfg_if.Cfg_valid = 1'b0;
    check("accA2_ready", 32'(cfg_if.Cfg_ready), 0);
    Rst = 1'b1;
    #1;
    check_cnt("mrst_cnt", 0, 0);
    check("mrst_hs", 32'(Hsync), 1);
    check("mrst_vs", 32'(Vsync), 1);
    check("mrst_ready", 32'(cfg_if.Cfg_ready), 1);
    check_margins("mrst_marg", 144, 783, 35, 514);
    Enable = 1'b0;
    tick();
    Rst = 1'b0;
    tick(2);
    check_margins("post_rst_marg", 144, 783, 35, 514);
    check("post_rst_state", 32'(Dbg_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
